// File: rtl/spongent_host_seq_pkg.sv
// Shared definitions for the SPONGENT host sequencer.
// State encoding is one-hot; PAD_BYTE is the leading byte of 10* padding.
// idx_width keeps counter widths legal when a count collapses to one.
package spongent_host_seq_pkg;

  typedef enum logic [7:0] {
    S_IDLE    = 8'b0000_0001,
    S_FILL    = 8'b0000_0010,
    S_PAD     = 8'b0000_0100,
    S_START   = 8'b0000_1000,
    S_WAIT_HI = 8'b0001_0000,
    S_WAIT_LO = 8'b0010_0000,
    S_EMIT    = 8'b0100_0000,
    S_SQZ     = 8'b1000_0000
  } state_t;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spongent_host_seq.sv
// Host sequencer: pads/packs message bytes into RATE-bit absorb blocks, then squeezes the digest.
// Latency: last absorb done -> first digest_valid 1 cycle; each further chunk 1 cycle + permutation.
// Backpressure: msg_ready low outside IDLE/FILL; digest held and no squeeze issued while digest_ready low.
module spongent_host_seq
  import spongent_host_seq_pkg::*;
#(
  parameter int RATE        = 16,
  parameter int DIGEST_BITS = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            msg_valid,
  output logic            msg_ready,
  input  logic [7:0]      msg_data,
  input  logic            msg_last,
  output logic            core_clear,
  output logic            core_start,
  output logic            core_msg_avail,
  output logic [RATE-1:0] core_msg_data,
  input  logic            core_busy,
  input  logic [RATE-1:0] core_rate,
  output logic            digest_valid,
  input  logic            digest_ready,
  output logic [RATE-1:0] digest_data,
  output logic            digest_last
);

  localparam int NBYTES = RATE / 8;
  localparam int NCHUNK = DIGEST_BITS / RATE;
  localparam int BW     = idx_width(NBYTES);
  localparam int CW     = idx_width(NCHUNK);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(NBYTES - 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  state_t          state, state_n;
  logic [BW-1:0]   byte_idx, byte_idx_n;
  logic [CW-1:0]   chunk, chunk_n;
  logic [RATE-1:0] block, block_n;
  logic [RATE-1:0] digest_q, digest_n;
  logic            more, more_n;
  logic            pad_pending, pad_pending_n;
  logic            squeezing, squeezing_n;
  logic            ready_q, ready_n;
  logic            accept;
  logic [BW-1:0]   wr_idx;

  // msg_ready is registered so it stays low throughout reset and every non-accepting state
  assign accept        = msg_valid & ready_q;
  assign wr_idx        = (state == S_IDLE) ? '0 : byte_idx;
  assign msg_ready     = ready_q;
  assign core_msg_data = block;
  assign digest_data   = digest_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Datapath registers: block under construction, counters, phase flags, digest chunk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx    <= '0;
      chunk       <= '0;
      block       <= '0;
      digest_q    <= '0;
      more        <= 1'b0;
      pad_pending <= 1'b0;
      squeezing   <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      byte_idx    <= byte_idx_n;
      chunk       <= chunk_n;
      block       <= block_n;
      digest_q    <= digest_n;
      more        <= more_n;
      pad_pending <= pad_pending_n;
      squeezing   <= squeezing_n;
      ready_q     <= ready_n;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_n        = state;
    byte_idx_n     = byte_idx;
    chunk_n        = chunk;
    block_n        = block;
    digest_n       = digest_q;
    more_n         = more;
    pad_pending_n  = pad_pending;
    squeezing_n    = squeezing;
    core_clear     = 1'b0;
    core_start     = 1'b0;
    core_msg_avail = 1'b0;
    digest_valid   = 1'b0;
    digest_last    = 1'b0;

    case (state)
      S_IDLE, S_FILL: begin
        if (accept) begin
          core_clear = (state == S_IDLE);
          // Write the byte; bytes beyond it are zeroed, and a final byte with room left gets 0x80 after it
          for (int j = 0; j < NBYTES; j++) begin
            if (j == int'(wr_idx))
              block_n[RATE-1-8*j -: 8] = msg_data;
            else if (j > int'(wr_idx))
              block_n[RATE-1-8*j -: 8] = (msg_last && (j == int'(wr_idx) + 1)) ? PAD_BYTE : 8'h00;
          end
          if (wr_idx == LAST_BYTE) begin
            more_n        = 1'b1;
            pad_pending_n = msg_last;
            byte_idx_n    = '0;
            state_n       = S_START;
          end else if (msg_last) begin
            more_n        = 1'b0;
            pad_pending_n = 1'b0;
            byte_idx_n    = '0;
            state_n       = S_START;
          end else begin
            byte_idx_n    = wr_idx + BW'(1);
            state_n       = S_FILL;
          end
        end
      end

      S_PAD: begin
        // Message ended exactly on a block boundary: the padding needs a block of its own
        block_n                = '0;
        block_n[RATE-1 -: 8]   = PAD_BYTE;
        more_n                 = 1'b0;
        pad_pending_n          = 1'b0;
        state_n                = S_START;
      end

      S_START: begin
        if (!core_busy) begin
          core_start     = 1'b1;
          core_msg_avail = 1'b1;
          state_n        = S_WAIT_HI;
        end
      end

      S_SQZ: begin
        if (!core_busy) begin
          core_start = 1'b1;
          state_n    = S_WAIT_HI;
        end
      end

      S_WAIT_HI: begin
        if (core_busy) state_n = S_WAIT_LO;
      end

      S_WAIT_LO: begin
        if (!core_busy) begin
          if (!squeezing && more) begin
            state_n = pad_pending ? S_PAD : S_FILL;
          end else begin
            digest_n    = core_rate;
            squeezing_n = 1'b1;
            state_n     = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        digest_valid = 1'b1;
        digest_last  = (chunk == LAST_CHUNK);
        if (digest_ready) begin
          if (chunk == LAST_CHUNK) begin
            chunk_n     = '0;
            squeezing_n = 1'b0;
            state_n     = S_IDLE;
          end else begin
            chunk_n = chunk + CW'(1);
            state_n = S_SQZ;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    ready_n = (state_n == S_IDLE) || (state_n == S_FILL);
  end

endmodule

// File: tb/tb_spongent_host_seq.sv
// Bench for spongent_host_seq: behavioural core model plus a message-level scoreboard.
// Expected blocks and digests come from padding/permutation arithmetic on the byte lists.
// A negedge monitor compares every handshake; literal block values pin the model.
module tb_spongent_host_seq;

  localparam int RATE = 16;
  localparam int DB   = 128;
  localparam int NCH  = DB / RATE;
  localparam int PERM = 20;

  typedef logic [7:0] bq_t[$];

  logic            clk = 1'b0;
  logic            reset;
  logic            msg_valid, msg_ready, msg_last;
  logic [7:0]      msg_data;
  logic            core_clear, core_start, core_msg_avail, core_busy;
  logic [RATE-1:0] core_msg_data, core_rate;
  logic            digest_valid, digest_ready, digest_last;
  logic [RATE-1:0] digest_data;

  spongent_host_seq #(.RATE(RATE), .DIGEST_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
    .core_clear(core_clear), .core_start(core_start), .core_msg_avail(core_msg_avail),
    .core_msg_data(core_msg_data), .core_busy(core_busy), .core_rate(core_rate),
    .digest_valid(digest_valid), .digest_ready(digest_ready),
    .digest_data(digest_data), .digest_last(digest_last)
  );

  always #5 clk = ~clk;

  // Stand-in permutation: any fixed bijective-ish mix works for checking data movement
  function automatic logic [15:0] perm(input logic [15:0] x);
    logic [15:0] y;
    y = x * 16'h9E37;
    return {y[10:0], y[15:11]} ^ 16'h3C5A;
  endfunction

  // Core model: busy rises the cycle after start, lasts PERM cycles, rate updates as busy falls
  int          cnt;
  logic [15:0] nxt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_busy <= 1'b0; cnt <= 0; core_rate <= '0; nxt <= '0;
    end else begin
      if (core_clear) core_rate <= '0;
      if (core_start && !core_busy) begin
        core_busy <= 1'b1;
        cnt       <= PERM;
        nxt       <= core_msg_avail ? perm(core_rate ^ core_msg_data) : perm(core_rate);
      end else if (core_busy) begin
        if (cnt == 1) begin
          core_busy <= 1'b0;
          core_rate <= nxt;
        end
        cnt <= cnt - 1;
      end
    end
  end

  int vecs = 0, fails = 0;
  logic [15:0] exp_blk[0:255];
  logic [15:0] exp_dig[0:255];
  logic [15:0] obs_blk[0:255];
  int exp_blk_wr = 0, exp_dig_wr = 0, abs_rd = 0, dig_rd = 0;
  int n_clear = 0, n_abs = 0, n_sqz = 0, n_dig = 0, n_done = 0, aborted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Message-level model: append 0x80, zero-fill to whole blocks, absorb from zero state, squeeze NCH chunks
  task automatic add_msg(input bq_t m);
    bq_t         p;
    logic [15:0] s, blk;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 2 != 0) p.push_back(8'h00);
    s = '0;
    for (int i = 0; i < p.size(); i += 2) begin
      blk = {p[i], p[i+1]};
      exp_blk[exp_blk_wr] = blk;
      exp_blk_wr++;
      s = perm(s ^ blk);
    end
    for (int k = 0; k < NCH; k++) begin
      if (k > 0) s = perm(s);
      exp_dig[exp_dig_wr] = s;
      exp_dig_wr++;
    end
  endtask

  task automatic monitor();
    logic [15:0] prev_dat = '0;
    logic [15:0] held_blk = '0;
    bit          prev_stall = 0;
    bit          absorbing = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        abs_rd     = exp_blk_wr;
        dig_rd     = exp_dig_wr;
        aborted    = n_clear - n_done;
        prev_stall = 0;
        absorbing  = 0;
      end else begin
        if (prev_stall) begin
          chk("bp_valid", 32'(digest_valid), 32'd1);
          chk("bp_data", 32'(digest_data), 32'(prev_dat));
          chk("bp_no_start", 32'(core_start), 32'd0);
        end
        if (core_busy) begin
          chk("ready_low_busy", 32'(msg_ready), 32'd0);
          if (absorbing) chk("blk_stable", 32'(core_msg_data), 32'(held_blk));
        end
        if (core_clear) begin
          chk("clear_after_done", 32'(n_clear - aborted), 32'(n_done));
          n_clear++;
        end
        if (core_start) begin
          absorbing = core_msg_avail;
          held_blk  = core_msg_data;
          if (core_msg_avail) begin
            if (abs_rd < exp_blk_wr) chk("absorb_blk", 32'(core_msg_data), 32'(exp_blk[abs_rd]));
            else chk("unexpected_absorb", 32'(abs_rd), 32'(exp_blk_wr - 1));
            obs_blk[n_abs % 256] = core_msg_data;
            abs_rd++;
            n_abs++;
          end else begin
            n_sqz++;
          end
        end
        if (digest_valid && digest_ready) begin
          if (dig_rd < exp_dig_wr) begin
            chk("digest_data", 32'(digest_data), 32'(exp_dig[dig_rd]));
            chk("digest_last", 32'(digest_last), 32'(dig_rd % NCH == NCH - 1));
          end else begin
            chk("unexpected_digest", 32'(dig_rd), 32'(exp_dig_wr - 1));
          end
          dig_rd++;
          n_dig++;
          if (digest_last) n_done++;
        end
        prev_stall = digest_valid && !digest_ready;
        prev_dat   = digest_data;
      end
    end
  endtask

  task automatic send(input bq_t m);
    for (int i = 0; i < m.size(); i++) begin
      int t = 0;
      bit got = 0;
      msg_valid = 1'b1;
      msg_data  = m[i];
      msg_last  = (i == m.size() - 1);
      while (!got && t < 3000) begin
        @(negedge clk);
        got = msg_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!got) chk("msg_accept_timeout", 32'(t), 32'd0);
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic consume(input int n, input int stall_at);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      bit seen = 0;
      while (!seen && t < 3000) begin
        @(negedge clk);
        seen = digest_valid;
        t++;
      end
      if (!seen) begin
        chk("digest_timeout", 32'(k), 32'(n));
        return;
      end
      if (k == stall_at) repeat (10) @(posedge clk);
      @(posedge clk);
      #1 digest_ready = 1'b1;
      @(posedge clk);
      #1 digest_ready = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_msg_ready"}, 32'(msg_ready), 32'd0);
    chk({tag, "_core_clear"}, 32'(core_clear), 32'd0);
    chk({tag, "_core_start"}, 32'(core_start), 32'd0);
    chk({tag, "_msg_avail"}, 32'(core_msg_avail), 32'd0);
    chk({tag, "_core_msg_data"}, 32'(core_msg_data), 32'd0);
    chk({tag, "_digest_valid"}, 32'(digest_valid), 32'd0);
    chk({tag, "_digest_data"}, 32'(digest_data), 32'd0);
    chk({tag, "_digest_last"}, 32'(digest_last), 32'd0);
  endtask

  task automatic run_msg(input string tag, input bq_t m, input int stall, input int nabs,
                         input logic [15:0] lit0, input logic [15:0] lit1, input logic [15:0] lit2);
    int c0, a0, s0, d0, k0;
    c0 = n_clear; a0 = n_abs; s0 = n_sqz; d0 = n_dig; k0 = n_done;
    add_msg(m);
    fork
      send(m);
      consume(NCH, stall);
    join
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_clears"}, 32'(n_clear - c0), 32'd1);
    chk({tag, "_absorbs"}, 32'(n_abs - a0), 32'(nabs));
    chk({tag, "_squeezes"}, 32'(n_sqz - s0), 32'(NCH - 1));
    chk({tag, "_chunks"}, 32'(n_dig - d0), 32'(NCH));
    chk({tag, "_lasts"}, 32'(n_done - k0), 32'd1);
    chk({tag, "_blk0"}, 32'(obs_blk[a0 % 256]), 32'(lit0));
    if (nabs > 1) chk({tag, "_blk1"}, 32'(obs_blk[(a0 + 1) % 256]), 32'(lit1));
    if (nabs > 2) chk({tag, "_blk2"}, 32'(obs_blk[(a0 + 2) % 256]), 32'(lit2));
  endtask

  initial begin
    int c0, a0, d0, t;
    reset = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; digest_ready = 1'b0;
    fork
      monitor();
      begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
      end
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    run_msg("one_byte", '{8'hAB}, -1, 1, 16'hAB80, 16'h0000, 16'h0000);
    run_msg("two_byte", '{8'h12, 8'h34}, -1, 2, 16'h1234, 16'h8000, 16'h0000);
    run_msg("five_byte", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, -1, 3, 16'h0102, 16'h0304, 16'h0580);
    run_msg("backpressure", '{8'h5A, 8'hC3, 8'h77}, 3, 2, 16'h5AC3, 16'h7780, 16'h0000);

    // Abort while the core is mid-permutation
    add_msg('{8'h11});
    send('{8'h11});
    t = 0;
    while (!core_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reached_busy", 32'(core_busy), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    @(posedge clk);
    #1 reset = 1'b0;
    run_msg("after_abort", '{8'hAB}, -1, 1, 16'hAB80, 16'h0000, 16'h0000);

    // Back-to-back messages with msg_valid held high across the boundary
    c0 = n_clear; a0 = n_abs; d0 = n_dig;
    add_msg('{8'h21});
    add_msg('{8'h43, 8'h65});
    fork
      begin
        send('{8'h21});
        send('{8'h43, 8'h65});
      end
      consume(2 * NCH, -1);
    join
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_clears", 32'(n_clear - c0), 32'd2);
    chk("b2b_absorbs", 32'(n_abs - a0), 32'd3);
    chk("b2b_chunks", 32'(n_dig - d0), 32'(2 * NCH));
    chk("b2b_blk0", 32'(obs_blk[a0 % 256]), 32'h2180);
    chk("b2b_blk1", 32'(obs_blk[(a0 + 1) % 256]), 32'h4365);
    chk("b2b_blk2", 32'(obs_blk[(a0 + 2) % 256]), 32'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
